edge_sync_det: RTL and testbench
================================

EDGE_SYNC_DET -- requirements
Module: edge_sync_det

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth, 2..4.
REQ-003 Parameter FILTER_CYCLES, default 4: consecutive stable samples required before a level change is accepted, 1..255.
REQ-004 Parameter INIT_LEVEL, default all-zero, CH bits: per-channel reset level of the synchroniser and the accepted level.
REQ-005 clk  input  1  single clock; every register is on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 sig_i  input  CH  asynchronous raw inputs.
REQ-008 mode_i  input  2*CH  per-channel event mode: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 clr_i  input  CH  per-channel sticky-flag clear, sampled each cycle.
REQ-010 level_o  output  CH  accepted (synchronised, filtered) level.
REQ-011 rise_o, fall_o  output  CH each  one-cycle pulses on accepted rising/falling changes, independent of mode_i.
REQ-012 event_o  output  CH  one-cycle pulse on a mode-qualified change.
REQ-013 flag_o  output  CH  sticky event flags; irq_o  output  1  OR of flag_o.

Function
REQ-014 Each channel SHALL pass sig_i through a SYNC_STAGES-deep flop chain; only the last stage (sync) feeds later logic.
REQ-015 The filter SHALL keep a per-channel counter of consecutive cycles with sync != level_o, and SHALL clear it on any cycle with sync == level_o.
REQ-016 level_o SHALL toggle on the edge where the counter would reach FILTER_CYCLES; the counter SHALL clear on that same edge.
REQ-017 rise_o/fall_o SHALL be registered and loaded on the same edge that updates level_o, high for exactly one cycle.
REQ-018 End-to-end latency SHALL be SYNC_STAGES+FILTER_CYCLES clock edges from the first edge sampling a new sig_i value to the pulse becoming visible.
REQ-019 event_o SHALL equal (rise_o & mode bit0) | (fall_o & mode bit1), using mode_i as sampled on the edge that loads the pulse.
REQ-020 A mode_i change SHALL never generate or retroactively raise an event.
REQ-021 flag_o SHALL set on event_o and hold until clr_i is high for that channel; when set and clear coincide on one edge, set SHALL win.
REQ-022 A bounce shorter than FILTER_CYCLES SHALL produce no pulse, and no change to level_o.
REQ-023 Back-to-back accepted changes SHALL produce separate pulses, minimum spacing FILTER_CYCLES cycles.
REQ-024 The counter SHALL saturate and never wrap; its width SHALL be clog2(FILTER_CYCLES+1).

Reset
REQ-025 reset SHALL force sync chains and level_o to INIT_LEVEL, counters to 0, and rise_o, fall_o, event_o, flag_o and irq_o to 0.
REQ-026 Deassertion with sig_i equal to INIT_LEVEL SHALL produce no pulse.
REQ-027 Reset mid-filter SHALL discard partial counts and SHALL not emit the pending event.

Configuration
REQ-028 Macro EDGE_SYNC_DET_FILTER_EN defined: the filter per REQ-015..016 SHALL be present.
REQ-029 Macro undefined: the counters SHALL be absent and level_o SHALL load sync every cycle, which gives latency SYNC_STAGES+1 edges; FILTER_CYCLES SHALL be ignored.

Structure
REQ-030 Package edge_sync_det_pkg SHALL hold the mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the counter-width function.
REQ-031 Per-channel logic SHALL be one sub-module, edge_sync_det_chan, instantiated CH times in a generate loop; irq_o SHALL be formed at top level.

Verification
REQ-032 CH=4, SYNC_STAGES=2, FILTER_CYCLES=4, filter on; ch0 0->1, mode 01 -> rise_o[0], event_o[0] and flag_o[0] high at edge 6; one-cycle pulses.
REQ-033 Glitch: ch1 high for 3 cycles, then low -> no pulse and level_o[1] stays 0; held 4 cycles -> rise_o[1] fires.
REQ-034 Mode 10 on ch2, input 0->1->0 with 10-cycle spacing -> rise_o[2] and fall_o[2] both pulse, event_o[2] only on the fall.
REQ-035 flag_o[3] set, clr_i[3] high on the same edge as a new event_o[3] -> flag_o[3] stays 1; next-cycle clear -> 0 and irq_o=0.
REQ-036 reset asserted two cycles into a 4-cycle filter window -> all outputs 0 immediately; no pulse after release with sig_i at INIT_LEVEL.
REQ-037 Filter compiled out, ch0 0->1 -> rise_o[0] at edge 3; a 1-cycle glitch also yields rise then fall pulses.

Source files
------------

// File: rtl/edge_sync_det_pkg.sv
// Shared definitions for the edge synchroniser / detector.
// Optional filter is enabled with the EDGE_SYNC_DET_FILTER_EN macro.
package edge_sync_det_pkg;

    // Per-channel event qualification taken from mode_i.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Width of a counter that must hold values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/edge_sync_det_chan.sv
// One channel: synchroniser chain, optional glitch filter (EDGE_SYNC_DET_FILTER_EN),
// registered rise/fall pulses, mode-qualified event pulse and a sticky flag.
module edge_sync_det_chan
    import edge_sync_det_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
`ifdef EDGE_SYNC_DET_FILTER_EN
    parameter int unsigned FILTER_CYCLES = 4,
`endif
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sig,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    output logic       o_level,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_event,
    output logic       o_flag
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   r_level;
    logic                   w_level_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_event;
    logic                   r_flag;
    logic                   w_rise_d;
    logic                   w_fall_d;
    logic                   w_event_d;
    logic                   w_flag_d;
    logic                   w_rise_en;
    logic                   w_fall_en;

    // Synchroniser shift chain; only the last stage is used downstream.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef EDGE_SYNC_DET_FILTER_EN
    localparam int unsigned CW = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CntLast = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_d;

    // Count consecutive disagreeing samples; accept the new level on the edge the
    // count would reach FILTER_CYCLES. The count restarts there, so it never wraps.
    always_comb begin
        w_cnt_d   = '0;
        w_level_d = r_level;
        if (w_sync != r_level) begin
            if (r_cnt == CntLast) begin
                w_level_d = w_sync;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    // Filter counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end
`else
    // Without the filter the accepted level simply follows the synchroniser.
    always_comb begin
        w_level_d = w_sync;
    end
`endif

    // Decode which accepted edges are reported as events.
    always_comb begin
        w_rise_en = 1'b0;
        w_fall_en = 1'b0;
        unique case (mode_e'(i_mode))
            MODE_OFF: begin
                w_rise_en = 1'b0;
                w_fall_en = 1'b0;
            end
            MODE_RISE: w_rise_en = 1'b1;
            MODE_FALL: w_fall_en = 1'b1;
            MODE_BOTH: begin
                w_rise_en = 1'b1;
                w_fall_en = 1'b1;
            end
        endcase
    end

    // Pulses derive from accepted level changes only, so a mode change alone is silent.
    always_comb begin
        w_rise_d  = w_level_d & ~r_level;
        w_fall_d  = ~w_level_d & r_level;
        w_event_d = (w_rise_d & w_rise_en) | (w_fall_d & w_fall_en);
        // Set has priority over a coincident clear.
        w_flag_d  = w_event_d | (r_flag & ~i_clr);
    end

    // Accepted level, edge pulses and sticky flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_event <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_level <= w_level_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
            r_event <= w_event_d;
            r_flag  <= w_flag_d;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_event = r_event;
    assign o_flag  = r_flag;

endmodule

// File: rtl/edge_sync_det.sv
// Multi-channel synchronising edge detector with sticky flags and a combined irq.
// Define EDGE_SYNC_DET_FILTER_EN to include the per-channel glitch filter.
module edge_sync_det
    import edge_sync_det_pkg::*;
#(
    parameter int unsigned   CH            = 4,
    parameter int unsigned   SYNC_STAGES   = 2,
    parameter int unsigned   FILTER_CYCLES = 4,
    parameter logic [CH-1:0] INIT_LEVEL    = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   sig_i,
    input  logic [2*CH-1:0] mode_i,
    input  logic [CH-1:0]   clr_i,
    output logic [CH-1:0]   level_o,
    output logic [CH-1:0]   rise_o,
    output logic [CH-1:0]   fall_o,
    output logic [CH-1:0]   event_o,
    output logic [CH-1:0]   flag_o,
    output logic            irq_o
);

    // Elaboration-time parameter range guards.
    if (CH < 1 || CH > 32) begin : g_bad_ch
        $error("edge_sync_det: CH must be within 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("edge_sync_det: SYNC_STAGES must be within 2..4");
    end
    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filt
        $error("edge_sync_det: FILTER_CYCLES must be within 1..255");
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        edge_sync_det_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
`ifdef EDGE_SYNC_DET_FILTER_EN
            .FILTER_CYCLES (FILTER_CYCLES),
`endif
            .INIT_LEVEL    (INIT_LEVEL[g])
        ) u_chan (
            .i_clk   (clk),
            .i_rst   (reset),
            .i_sig   (sig_i[g]),
            .i_mode  (mode_i[2*g +: 2]),
            .i_clr   (clr_i[g]),
            .o_level (level_o[g]),
            .o_rise  (rise_o[g]),
            .o_fall  (fall_o[g]),
            .o_event (event_o[g]),
            .o_flag  (flag_o[g])
        );
    end

    assign irq_o = |flag_o;

endmodule

// File: tb/tb_edge_sync_det.sv
// Directed self-checking bench for edge_sync_det (CH=4, SYNC_STAGES=2, FILTER_CYCLES=4).
// Expectations follow EDGE_SYNC_DET_FILTER_EN as seen by this compile.
module tb_edge_sync_det;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FC = 4;
`ifdef EDGE_SYNC_DET_FILTER_EN
    localparam int LAT = SS + FC;
`else
    localparam int LAT = SS + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] sig;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] clr;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] evt;
    logic [CH-1:0] flag;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    edge_sync_det #(
        .CH            (CH),
        .SYNC_STAGES   (SS),
        .FILTER_CYCLES (FC),
        .INIT_LEVEL    ('0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sig_i   (sig),
        .mode_i  (mode),
        .clr_i   (clr),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall),
        .event_o (evt),
        .flag_o  (flag),
        .irq_o   (irq)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive sig[ch]=val, invert it after edge 'hold', and check pulses on every edge 1..n.
    task automatic watch(input int ch, input logic val, input int hold, input int n,
                         input int rise_at, input int fall_at, input int ev_at,
                         input logic lvl_end);
        logic [CH-1:0] er;
        logic [CH-1:0] ef;
        logic [CH-1:0] ee;
        sig[ch] = val;
        for (int k = 1; k <= n; k++) begin
            step();
            er = '0;
            ef = '0;
            ee = '0;
            if (k == rise_at) er[ch] = 1'b1;
            if (k == fall_at) ef[ch] = 1'b1;
            if (k == ev_at)   ee[ch] = 1'b1;
            check($sformatf("rise ch%0d edge%0d", ch, k), rise, er);
            check($sformatf("fall ch%0d edge%0d", ch, k), fall, ef);
            check($sformatf("event ch%0d edge%0d", ch, k), evt, ee);
            if (k == hold) sig[ch] = ~val;
        end
        check($sformatf("level ch%0d end", ch), level[ch], lvl_end);
    endtask

    initial begin
        reset = 1'b1;
        sig   = '0;
        mode  = '0;
        clr   = '0;
        step();
        step();
        check("rst level", level, 0);
        check("rst rise", rise, 0);
        check("rst fall", fall, 0);
        check("rst event", evt, 0);
        check("rst flag", flag, 0);
        check("rst irq", irq, 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("post-rst rise %0d", k), rise, 0);
            check($sformatf("post-rst fall %0d", k), fall, 0);
            check($sformatf("post-rst event %0d", k), evt, 0);
        end

        // ch0 rise with mode 01: pulse LAT edges after first sampling edge.
        mode[1:0] = 2'b01;
        watch(0, 1'b1, 1000, LAT + 2, LAT, 0, LAT, 1'b1);
        check("A flag", flag, 4'b0001);
        check("A irq", irq, 1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        check("A flag clr", flag, 0);
        check("A irq clr", irq, 0);
        watch(0, 1'b0, 1000, LAT + 1, 0, LAT, 0, 1'b0);
        check("A fall no flag", flag, 0);

        // Glitch handling on ch1.
        mode[3:2] = 2'b01;
`ifdef EDGE_SYNC_DET_FILTER_EN
        watch(1, 1'b1, 3, 12, 0, 0, 0, 1'b0);
        check("B glitch flag", flag, 0);
        watch(1, 1'b1, 1000, LAT + 1, LAT, 0, LAT, 1'b1);
        watch(1, 1'b0, 1000, LAT + 1, 0, LAT, 0, 1'b0);
`else
        watch(1, 1'b1, 1, 6, LAT, LAT + 1, LAT, 1'b0);
`endif
        check("B flag", flag, 4'b0010);

        // ch2 fall-only mode: both pulses, event only on the fall.
        mode[5:4] = 2'b10;
        watch(2, 1'b1, 10, 10 + LAT + 2, LAT, 10 + LAT, 10 + LAT, 1'b0);
        check("C flag", flag, 4'b0110);

        // Mode changes on steady inputs must stay silent.
        mode[5:4] = 2'b11;
        mode[3:2] = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("mode chg event %0d", k), evt, 0);
            check($sformatf("mode chg flag %0d", k), flag, 4'b0110);
        end
        clr = 4'b0110;
        step();
        clr = '0;
        check("C clr flag", flag, 0);
        check("C clr irq", irq, 0);

        // ch3: set and clear on the same edge, set wins; clear next edge.
        mode[7:6] = 2'b11;
        watch(3, 1'b1, 1000, LAT + 1, LAT, 0, LAT, 1'b1);
        check("D flag set", flag, 4'b1000);
        check("D irq set", irq, 1);
        sig[3] = 1'b0;
        repeat (LAT - 1) step();
        clr[3] = 1'b1;
        step();
        check("D coincide event", evt, 4'b1000);
        check("D coincide fall", fall, 4'b1000);
        check("D coincide flag", flag, 4'b1000);
        step();
        clr[3] = 1'b0;
        check("D cleared flag", flag, 0);
        check("D cleared irq", irq, 0);
        check("D event gone", evt, 0);

        // Reset in the middle of a pending ch0 change.
        watch(3, 1'b1, 1000, LAT + 1, LAT, 0, LAT, 1'b1);
        sig[0] = 1'b1;
        repeat (LAT - 2) step();
        reset = 1'b1;
        #1;
        check("E async level", level, 0);
        check("E async flag", flag, 0);
        check("E async irq", irq, 0);
        check("E async rise", rise, 0);
        check("E async fall", fall, 0);
        check("E async event", evt, 0);
        sig = '0;
        step();
        step();
        reset = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            step();
            check($sformatf("E rise %0d", k), rise, 0);
            check($sformatf("E fall %0d", k), fall, 0);
            check($sformatf("E event %0d", k), evt, 0);
            check($sformatf("E level %0d", k), level, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
